// File: rtl/peripheral_bfm_master_generic_bb.sv
// Command-driven AXI master BFM: one read/write INCR burst per command, results on the rsp port.
// Optional watchdog abort enabled by defining PERIPHERAL_BFM_MASTER_TIMEOUT_EN.
module peripheral_bfm_master_generic_bb #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_id,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_strb,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_resp,
    output logic        rsp_last,
    output logic [3:0]  awid,
    output logic [31:0] awadr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  abburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wrdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

    state_t      state_q;
    logic        cmd_ready_q, awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
    logic        rsp_valid_q, rsp_last_q;
    logic [1:0]  rsp_resp_q, burst_q;
    logic [2:0]  size_q;
    logic [3:0]  id_q, len_q, strb_q, beat_q;
    logic [31:0] addr_q, data_q, wrdata_q, rsp_data_q;
    logic        timeout;

`ifdef PERIPHERAL_BFM_MASTER_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        hs;

    // Any handshake, or sitting in IDLE (which covers state entry from IDLE), restarts the watchdog.
    assign hs = (awvalid_q & awready) | (wvalid_q & wready) | (bready_q & bvalid)
              | (arvalid_q & arready) | (rready_q & rvalid);

    always_ff @(posedge aclk) begin
        if (areset || state_q == IDLE || hs) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 16'd1;
        end
    end

    assign timeout = (state_q != IDLE) && (wdog_q == 16'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    logic unused_inputs;
    assign unused_inputs = ^{bid, rid, rlast, cmd_addr[1:0]};

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_resp_q  <= '0;
            rsp_data_q  <= '0;
            burst_q     <= '0;
            size_q      <= '0;
            id_q        <= '0;
            len_q       <= '0;
            strb_q      <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wrdata_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (timeout) begin
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                wlast_q     <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_resp_q  <= 2'b11;
                rsp_last_q  <= 1'b1;
                rsp_data_q  <= '0;
                state_q     <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_valid && cmd_ready_q) begin
                            cmd_ready_q <= 1'b0;
                            id_q        <= cmd_id;
                            addr_q      <= {cmd_addr[31:2], 2'b00};
                            len_q       <= cmd_len;
                            size_q      <= 3'b010;
                            burst_q     <= 2'b01;
                            strb_q      <= cmd_strb;
                            data_q      <= cmd_data;
                            beat_q      <= '0;
                            if (cmd_write) begin
                                awvalid_q <= 1'b1;
                                state_q   <= WADDR;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= RADDR;
                            end
                        end else begin
                            cmd_ready_q <= 1'b1;
                        end
                    end
                    WADDR: if (awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wrdata_q  <= data_q;
                        wlast_q   <= (len_q == 4'd0);
                        state_q   <= WDATA;
                    end
                    WDATA: if (wready) begin
                        if (beat_q == len_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= WRESP;
                        end else begin
                            beat_q   <= beat_q + 4'd1;
                            wrdata_q <= data_q + 32'(beat_q) + 32'd1;
                            wlast_q  <= (beat_q + 4'd1 == len_q);
                        end
                    end
                    WRESP: if (bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= bresp;
                        rsp_last_q  <= 1'b1;
                        rsp_data_q  <= '0;
                        state_q     <= IDLE;
                    end
                    RADDR: if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RDATA;
                    end
                    // Burst length is tracked by beat count; rlast from the slave is not trusted.
                    RDATA: if (rvalid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rdata;
                        rsp_resp_q  <= rresp;
                        rsp_last_q  <= (beat_q == len_q);
                        if (beat_q == len_q) begin
                            rready_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_last  = rsp_last_q;
    assign awid      = id_q;
    assign awadr     = addr_q;
    assign awlen     = len_q;
    assign awsize    = size_q;
    assign abburst   = burst_q;
    assign awlock    = '0;
    assign awcache   = '0;
    assign awprot    = '0;
    assign awvalid   = awvalid_q;
    assign wid       = id_q;
    assign wrdata    = wrdata_q;
    assign wstrb     = strb_q;
    assign wlast     = wlast_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign arid      = id_q;
    assign araddr    = addr_q;
    assign arlen     = len_q;
    assign arsize    = size_q;
    assign arlock    = '0;
    assign arcache   = '0;
    assign arprot    = '0;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;

endmodule

// File: tb/tb_peripheral_bfm_master_generic_bb.sv
// Directed bench for peripheral_bfm_master_generic_bb; the testbench plays the AXI slave by hand.
module tb_peripheral_bfm_master_generic_bb;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id, cmd_len, cmd_strb;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid, rsp_last;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [3:0]  awid, awlen, awcache, wid, wstrb, bid, arid, arlen, arcache, rid;
    logic [31:0] awadr, wrdata, araddr, rdata;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  abburst, awlock, bresp, arlock, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int k, pulses, cyc;
    logic was_v;

    peripheral_bfm_master_generic_bb #(.TIMEOUT(16)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .abburst(abburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [31:0] data, input logic [3:0] strb);
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) step();
        check("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
        cmd_len = len; cmd_data = data; cmd_strb = strb;
        step();
        cmd_valid = 1'b0;
        check("cmd_ready_after_accept", {31'd0, cmd_ready}, 32'd0);
    endtask

    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0;
        cmd_len = '0; cmd_data = '0; cmd_strb = '0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0; arready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        step(); step(); step();

        // Reset state
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_valids", {27'd0, awvalid, wvalid, arvalid, rsp_valid, bready}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_awsize", {29'd0, awsize}, 32'd0);
        areset = 1'b0;
        step();
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Single-beat write
        send_cmd(1'b1, 4'h3, 32'h10, 4'd0, 32'hA5A5A5A5, 4'hF);
        check("w1_awvalid", {31'd0, awvalid}, 32'd1);
        check("w1_awadr", awadr, 32'h10);
        check("w1_awlen", {28'd0, awlen}, 32'd0);
        check("w1_awsize", {29'd0, awsize}, 32'd2);
        check("w1_abburst", {30'd0, abburst}, 32'd1);
        check("w1_awid", {28'd0, awid}, 32'd3);
        awready = 1'b1;
        step();
        awready = 1'b0;
        check("w1_awvalid_drop", {31'd0, awvalid}, 32'd0);
        check("w1_wvalid", {31'd0, wvalid}, 32'd1);
        check("w1_wrdata", wrdata, 32'hA5A5A5A5);
        check("w1_wlast", {31'd0, wlast}, 32'd1);
        check("w1_wstrb", {28'd0, wstrb}, 32'hF);
        wready = 1'b1;
        step();
        wready = 1'b0;
        check("w1_wvalid_drop", {31'd0, wvalid}, 32'd0);
        check("w1_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        check("w1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("w1_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        check("w1_rsp_last", {31'd0, rsp_last}, 32'd1);
        check("w1_rsp_data", rsp_data, 32'd0);
        check("w1_cmd_ready_lag", {31'd0, cmd_ready}, 32'd0);
        step();
        check("w1_rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        check("w1_cmd_ready_rise", {31'd0, cmd_ready}, 32'd1);

        // Single-beat read of the same address
        send_cmd(1'b0, 4'h4, 32'h10, 4'd0, 32'h0, 4'h0);
        check("r1_arvalid", {31'd0, arvalid}, 32'd1);
        check("r1_araddr", araddr, 32'h10);
        check("r1_arlen", {28'd0, arlen}, 32'd0);
        check("r1_arsize", {29'd0, arsize}, 32'd2);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("r1_arvalid_drop", {31'd0, arvalid}, 32'd0);
        check("r1_rready", {31'd0, rready}, 32'd1);
        rvalid = 1'b1; rdata = 32'hA5A5A5A5; rresp = 2'b00; rlast = 1'b1;
        step();
        rvalid = 1'b0; rlast = 1'b0;
        check("r1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("r1_rsp_data", rsp_data, 32'hA5A5A5A5);
        check("r1_rsp_last", {31'd0, rsp_last}, 32'd1);
        check("r1_rready_drop", {31'd0, rready}, 32'd0);

        // Four-beat write with address stall and wready low every other cycle
        send_cmd(1'b1, 4'h7, 32'h0000_0102, 4'd3, 32'h100, 4'h3);
        step(); step();
        check("w4_aw_held", {31'd0, awvalid}, 32'd1);
        check("w4_awadr_aligned", awadr, 32'h100);
        check("w4_awlen", {28'd0, awlen}, 32'd3);
        awready = 1'b1;
        step();
        awready = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            check("w4_wvalid", {31'd0, wvalid}, 32'd1);
            check("w4_wrdata", wrdata, 32'h100 + 32'(k));
            check("w4_wlast", {31'd0, wlast}, (k == 3) ? 32'd1 : 32'd0);
            check("w4_wstrb", {28'd0, wstrb}, 32'h3);
            wready = (c % 2 == 1);
            step();
            if (wready) k++;
            wready = 1'b0;
        end
        check("w4_beats", 32'(k), 32'd4);
        check("w4_wvalid_drop", {31'd0, wvalid}, 32'd0);
        check("w4_bready", {31'd0, bready}, 32'd1);
        step();
        check("w4_bready_held", {31'd0, bready}, 32'd1);
        check("w4_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
        bvalid = 1'b1; bresp = 2'b10;
        step();
        bvalid = 1'b0;
        check("w4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("w4_rsp_resp", {30'd0, rsp_resp}, 32'd2);
        check("w4_rsp_last", {31'd0, rsp_last}, 32'd1);

        // Three-beat read with gapped rvalid; rlast from the slave is deliberately wrong
        send_cmd(1'b0, 4'h5, 32'h0000_0203, 4'd2, 32'h0, 4'h0);
        check("r3_araddr_aligned", araddr, 32'h200);
        check("r3_arid", {28'd0, arid}, 32'd5);
        arready = 1'b1;
        step();
        arready = 1'b0;
        k = 0; pulses = 0;
        for (int c = 0; c < 12 && k < 3; c++) begin
            rvalid = (c % 3 == 2);
            rdata  = 32'hD000 + 32'(k);
            rresp  = 2'b01;
            rlast  = (k == 0);
            was_v  = rvalid;
            step();
            rvalid = 1'b0; rlast = 1'b0;
            check("r3_pulse", {31'd0, rsp_valid}, {31'd0, was_v});
            if (rsp_valid === 1'b1) pulses++;
            if (was_v) begin
                check("r3_rsp_data", rsp_data, 32'hD000 + 32'(k));
                check("r3_rsp_resp", {30'd0, rsp_resp}, 32'd1);
                check("r3_rsp_last", {31'd0, rsp_last}, (k == 2) ? 32'd1 : 32'd0);
                k++;
            end
        end
        check("r3_pulses", 32'(pulses), 32'd3);
        check("r3_rready_drop", {31'd0, rready}, 32'd0);
        rvalid = 1'b1;
        step();
        rvalid = 1'b0;
        check("r3_no_extra_rsp", {31'd0, rsp_valid}, 32'd0);

        // Reset in the middle of a write burst
        send_cmd(1'b1, 4'h1, 32'h300, 4'd3, 32'h300, 4'hF);
        awready = 1'b1;
        step();
        awready = 1'b0;
        wready = 1'b1;
        step();
        wready = 1'b0;
        check("rw_beat1_data", wrdata, 32'h301);
        areset = 1'b1;
        step();
        check("rw_valids_cleared", {27'd0, awvalid, wvalid, arvalid, rsp_valid, bready}, 32'd0);
        check("rw_cmd_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
        areset = 1'b0;
        step();
        check("rw_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid === 1'b1 || wvalid === 1'b1 || bready === 1'b1) pulses++;
            step();
        end
        check("rw_no_activity", 32'(pulses), 32'd0);

`ifdef PERIPHERAL_BFM_MASTER_TIMEOUT_EN
        // Watchdog abort with the address channel never ready
        send_cmd(1'b1, 4'h2, 32'h40, 4'd0, 32'h1, 4'hF);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        check("to_cycles", 32'(cyc), 32'd16);
        check("to_rsp_resp", {30'd0, rsp_resp}, 32'd3);
        check("to_rsp_last", {31'd0, rsp_last}, 32'd1);
        check("to_awvalid", {31'd0, awvalid}, 32'd0);
        step();
        check("to_idle", {31'd0, cmd_ready}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
